// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin / fixed-priority arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  // hold_cnt must reach MAX_HOLD, which may be as large as 255
  localparam int HOLD_W = 8;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational selector: first set bit of (req & mask), scanning upward from start with wrap.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] index
);

  logic [N-1:0] cand;
  int           k;

  assign cand = req & mask;

  always_comb begin
    found = 1'b0;
    index = '0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(start) + i;
      if (k >= N) k = k - N;
      if (!found && cand[k[IW-1:0]]) begin
        found = 1'b1;
        index = k[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// N-way arbiter with registered one-hot grant, round-robin or fixed priority,
// and a hold limit that forces hand-over when others are waiting.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MODE     = 0,
  parameter int MAX_HOLD = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N-1:0]            req,
  output logic [N-1:0]            gnt,
  output logic                    gnt_valid,
  output logic [id_width(N)-1:0]  gnt_id,
  output arb_state_e              state_dbg
);

  localparam int                IW       = id_width(N);
  localparam logic [N-1:0]      ONE      = {{(N-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0]     LAST_IDX = IW'(N - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  arb_state_e        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [IW-1:0]     last_id;

  logic [N-1:0]      pick_mask;
  logic [IW-1:0]     pick_start;
  logic [IW-1:0]     pick_idx;
  logic              pick_found;
  logic              holder_req;
  logic              at_limit;
  logic              do_grant;
  logic              do_release;

  assign holder_req = req[gnt_id];
  assign at_limit   = (hold_cnt == HOLD_MAX);

  // While busy the holder is masked out: on release its req is low anyway,
  // and on a forced hand-over it must not win again.
  assign pick_mask  = (state == BUSY) ? ~(ONE << gnt_id) : '1;
  assign pick_start = (MODE == MODE_FIXED) ? '0 :
                      ((last_id == LAST_IDX) ? '0 : last_id + 1'b1);

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .mask  (pick_mask),
    .start (pick_start),
    .found (pick_found),
    .index (pick_idx)
  );

  assign do_grant   = pick_found && ((state == IDLE) || !holder_req || at_limit);
  assign do_release = (state == BUSY) && !holder_req && !pick_found;
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      hold_cnt  <= '0;
      last_id   <= LAST_IDX;
    end else if (do_grant) begin
      state     <= BUSY;
      gnt       <= ONE << pick_idx;
      gnt_valid <= 1'b1;
      gnt_id    <= pick_idx;
      hold_cnt  <= HOLD_W'(1);
      last_id   <= pick_idx;
    end else if (do_release) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      hold_cnt  <= '0;
    end else if ((state == BUSY) && !at_limit) begin
      hold_cnt  <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter MODE, default 0, 0 = round-robin, 1 = fixed priority (index 0 highest).
REQ-003 SHALL have parameter MAX_HOLD, default 8, maximum consecutive grant cycles while another requester waits (1..255).
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req  input  N  per-requester request level.
REQ-007 SHALL have port gnt  output  N  registered one-hot grant, or all-zero.
REQ-008 SHALL have port gnt_valid  output  1  registered, high when any gnt bit is high.
REQ-009 SHALL have port gnt_id  output  max(1,$clog2(N))  registered index of the granted requester, 0 when gnt_valid is low.

Function
REQ-010 SHALL use two states: IDLE (no grant) and BUSY (one grant held).
REQ-011 SHALL, in IDLE with req != 0 at a rising edge, enter BUSY and assert the selected grant after that edge (1-cycle latency).
REQ-012 SHALL, in IDLE with req == 0, remain in IDLE with gnt = 0.
REQ-013 SHALL, in MODE 0, select the first requesting index searching upward from (last_id+1) mod N with wrap-around.
REQ-014 SHALL, in MODE 1, select the lowest requesting index and ignore last_id.
REQ-015 SHALL update last_id to the granted index on every new grant.
REQ-016 SHALL hold the grant in BUSY while the holder's req stays high, unless REQ-018 applies.
REQ-017 SHALL, when the holder drops req: switch directly to the next selection on that edge if any other req is high (no idle bubble); otherwise go to IDLE with gnt = 0.
REQ-018 SHALL force reselection when hold_cnt == MAX_HOLD and any other requester is high; the current holder is excluded from that selection.
REQ-019 SHALL load hold_cnt with 1 on each new grant, increment it each BUSY cycle, and saturate it at MAX_HOLD.
REQ-020 SHALL keep the holder granted indefinitely when it is the only requester, with hold_cnt saturated.
REQ-021 SHALL never assert more than one gnt bit in any cycle.
REQ-022 SHALL make gnt, gnt_valid and gnt_id change only on rising clk edges or reset, with no combinational path from req.
REQ-023 SHALL treat a new req arriving in the same cycle as the holder's release as a candidate in that same selection.

Reset
REQ-024 SHALL on rst_n low, immediately and asynchronously, set: state = IDLE, gnt = 0, gnt_valid = 0, gnt_id = 0, hold_cnt = 0, last_id = N-1 (so the first search starts at index 0).
REQ-025 SHALL, when reset is asserted mid-grant, drop the grant in the same cycle and restart arbitration from index 0 after release.
REQ-026 SHALL start arbitrating on the first rising edge after rst_n deasserts.

Structure
REQ-027 SHALL place the state enum (IDLE, BUSY) and the MODE constants (MODE_RR, MODE_FIXED) in shared package arb_pkg.
REQ-028 SHALL implement selection in one combinational sub-module, rr_pick (inputs: req, mask, start index; outputs: found, index), instantiated once.

Verification (N=4, MAX_HOLD=4)
REQ-029 SHALL cover reset mid-grant: req=0001, gnt=0001, then rst_n low -> gnt=0000 with no clock edge; after release with req=0001 -> gnt=0001 one cycle later.
REQ-030 SHALL cover round-robin rotation, MODE 0: req=1111, each holder drops req after 1 cycle and re-raises it -> grant order 0,1,2,3,0 with no idle cycles.
REQ-031 SHALL cover hold limit: req=0011 held constant -> gnt=0001 for 4 cycles, then 0010 for 4 cycles, then 0001.
REQ-032 SHALL cover sole requester: req=0100 for 20 cycles -> gnt=0100 throughout, gnt_id=2.
REQ-033 SHALL cover fixed priority, MODE 1: holder 3 releases while req=0110 -> next gnt=0010; index 2 is granted only after index 1 releases or reaches the hold limit.
REQ-034 SHALL cover release to idle: the sole holder drops req -> gnt=0000 and gnt_valid=0 on the next edge; req=1000 re-raised -> gnt=1000 one cycle later.
